// File: rtl/x87_op_collect.sv
// x87_op_collect: assembles one x87 instruction (escape byte, ModR/M,
// optional SIB and displacement) from the in-order instruction byte stream
// and presents it as a single packet on a valid/ready output.
module x87_op_collect #(
  parameter int DISP_SEXT = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             addr32,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_op1,
  output logic [7:0]       out_op2,
  output logic             out_op2_valid,
  output logic             out_is_mem,
  output logic             out_has_sib,
  output logic [7:0]       out_sib,
  output logic [31:0]      out_disp,
  output logic [2:0]       out_disp_len,
  output logic [CNT_W-1:0] skip_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MODRM,
    ST_SIB,
    ST_DISP,
    ST_OUT
  } state_e;

  state_e state_q, state_d;

  // Working copy of the packet being assembled.
  logic [7:0]       op1_q, op1_d;
  logic [7:0]       op2_q, op2_d;
  logic             op2v_q, op2v_d;
  logic             mem_q, mem_d;
  logic             hasSib_q, hasSib_d;
  logic [7:0]       sib_q, sib_d;
  logic [31:0]      disp_q, disp_d;
  logic [2:0]       len_q, len_d;
  logic [1:0]       mod_q, mod_d;
  logic             a32_q, a32_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] skip_q, skip_d;

  // Published packet; only updated on entry to ST_OUT or cleared on abort.
  logic [7:0]  outOp1_q;
  logic [7:0]  outOp2_q;
  logic        outOp2v_q;
  logic        outMem_q;
  logic        outHasSib_q;
  logic [7:0]  outSib_q;
  logic [31:0] outDisp_q;
  logic [2:0]  outLen_q;

  logic       accept;
  logic       load;
  logic [1:0] byteMod;
  logic [2:0] byteRm;
  logic [2:0] modrmLen;
  logic       modrmSib;
  logic       isEscape;

  assign in_ready  = (state_q != ST_OUT) && !flush;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_OUT);
  assign byteMod   = in_byte[7:6];
  assign byteRm    = in_byte[2:0];
  assign isEscape  = (in_byte[7:3] == 5'b11011);

  // ModR/M decode: displacement length and SIB presence for the latched address size.
  always_comb begin
    modrmLen = 3'd0;
    modrmSib = 1'b0;
    if (a32_q) begin
      modrmSib = (byteMod != 2'b11) && (byteRm == 3'b100);
      case (byteMod)
        2'b00:   modrmLen = (byteRm == 3'b101) ? 3'd4 : 3'd0;
        2'b01:   modrmLen = 3'd1;
        2'b10:   modrmLen = 3'd4;
        default: modrmLen = 3'd0;
      endcase
    end else begin
      case (byteMod)
        2'b00:   modrmLen = (byteRm == 3'b110) ? 3'd2 : 3'd0;
        2'b01:   modrmLen = 3'd1;
        2'b10:   modrmLen = 3'd2;
        default: modrmLen = 3'd0;
      endcase
    end
  end

  // Next-state and working-field update for the collection state machine.
  always_comb begin
    state_d  = state_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op2v_d   = op2v_q;
    mem_d    = mem_q;
    hasSib_d = hasSib_q;
    sib_d    = sib_q;
    disp_d   = disp_q;
    len_d    = len_q;
    mod_d    = mod_q;
    a32_d    = a32_q;
    cnt_d    = cnt_q;
    skip_d   = skip_q;
    load     = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (in_byte == 8'h9B) begin
              op1_d    = 8'h9B;
              op2_d    = 8'h00;
              op2v_d   = 1'b0;
              mem_d    = 1'b0;
              hasSib_d = 1'b0;
              sib_d    = 8'h00;
              disp_d   = 32'h0;
              len_d    = 3'd0;
              state_d  = ST_OUT;
              load     = 1'b1;
            end else if (isEscape) begin
              op1_d    = in_byte;
              a32_d    = addr32;
              hasSib_d = 1'b0;
              sib_d    = 8'h00;
              disp_d   = 32'h0;
              len_d    = 3'd0;
              state_d  = ST_MODRM;
            end else if (skip_q != {CNT_W{1'b1}}) begin
              skip_d = skip_q + 1'b1;
            end
          end
        end

        ST_MODRM: begin
          if (accept) begin
            op2_d  = in_byte;
            op2v_d = 1'b1;
            mem_d  = (byteMod != 2'b11);
            mod_d  = byteMod;
            len_d  = modrmLen;
            cnt_d  = 2'd0;
            if (modrmSib) begin
              state_d = ST_SIB;
            end else if (modrmLen != 3'd0) begin
              state_d = ST_DISP;
            end else begin
              state_d = ST_OUT;
              load    = 1'b1;
            end
          end
        end

        ST_SIB: begin
          if (accept) begin
            sib_d    = in_byte;
            hasSib_d = 1'b1;
            if ((mod_q == 2'b00) && (in_byte[2:0] == 3'b101)) begin
              len_d = 3'd4;
            end
            cnt_d = 2'd0;
            if (len_d != 3'd0) begin
              state_d = ST_DISP;
            end else begin
              state_d = ST_OUT;
              load    = 1'b1;
            end
          end
        end

        ST_DISP: begin
          if (accept) begin
            case (cnt_q)
              2'd0:    disp_d[7:0]   = in_byte;
              2'd1:    disp_d[15:8]  = in_byte;
              2'd2:    disp_d[23:16] = in_byte;
              default: disp_d[31:24] = in_byte;
            endcase
            cnt_d = cnt_q + 2'd1;
            if ({1'b0, cnt_q} == (len_q - 3'd1)) begin
              if (len_q == 3'd1) begin
                disp_d[31:8] = (DISP_SEXT != 0) ? {24{in_byte[7]}} : 24'h0;
              end else if (len_q == 3'd2) begin
                disp_d[31:16] = (DISP_SEXT != 0) ? {16{in_byte[7]}} : 16'h0;
              end
              state_d = ST_OUT;
              load    = 1'b1;
            end
          end
        end

        ST_OUT: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and working-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op1_q    <= 8'h00;
      op2_q    <= 8'h00;
      op2v_q   <= 1'b0;
      mem_q    <= 1'b0;
      hasSib_q <= 1'b0;
      sib_q    <= 8'h00;
      disp_q   <= 32'h0;
      len_q    <= 3'd0;
      mod_q    <= 2'b00;
      a32_q    <= 1'b0;
      cnt_q    <= 2'd0;
      skip_q   <= '0;
    end else begin
      state_q  <= state_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op2v_q   <= op2v_d;
      mem_q    <= mem_d;
      hasSib_q <= hasSib_d;
      sib_q    <= sib_d;
      disp_q   <= disp_d;
      len_q    <= len_d;
      mod_q    <= mod_d;
      a32_q    <= a32_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
    end
  end

  // Published packet: captured on entry to ST_OUT, cleared on reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      outOp1_q    <= 8'h00;
      outOp2_q    <= 8'h00;
      outOp2v_q   <= 1'b0;
      outMem_q    <= 1'b0;
      outHasSib_q <= 1'b0;
      outSib_q    <= 8'h00;
      outDisp_q   <= 32'h0;
      outLen_q    <= 3'd0;
    end else if (load) begin
      outOp1_q    <= op1_d;
      outOp2_q    <= op2_d;
      outOp2v_q   <= op2v_d;
      outMem_q    <= mem_d;
      outHasSib_q <= hasSib_d;
      outSib_q    <= sib_d;
      outDisp_q   <= disp_d;
      outLen_q    <= len_d;
    end
  end

  assign out_op1       = outOp1_q;
  assign out_op2       = outOp2_q;
  assign out_op2_valid = outOp2v_q;
  assign out_is_mem    = outMem_q;
  assign out_has_sib   = outHasSib_q;
  assign out_sib       = outSib_q;
  assign out_disp      = outDisp_q;
  assign out_disp_len  = outLen_q;
  assign skip_cnt      = skip_q;

endmodule
